// File: rtl/seq_det_frame_ctrl.sv
// Frame sequencer for an external 1011 serial pattern detector.
// Takes parallel words from a valid/ready stream, shifts them out MSB-first
// one bit per clock, keeps the detector in reset between frames and counts
// detect pulses per frame. Results hold until the next frame starts.
module seq_det_frame_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   output logic              det_rst_n_o,
   output logic              det_data_o,
   input  logic              det_detect_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  match_cnt_o,
   output logic              match_any_o,
   output logic              underrun_o
);

   localparam int BC_W = $clog2(WORD_W);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(WORD_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]        state;
   logic [WORD_W-1:0] sh;
   logic [BC_W-1:0]   bitcnt;
   logic              last_q;
   logic [CNT_W-1:0]  match_cnt;
   logic              underrun;
   logic              det_rst_n;

   logic at_boundary;
   logic accept;

   // Word boundary: the last bit of the current word is on the wire this cycle.
   assign at_boundary = (state == S_SHIFT) && (bitcnt == '0);

   // Ready depends only on state/bit counter/last flag so upstream can wait on it.
   assign s_ready = (state == S_IDLE) || (at_boundary && !last_q);
   assign accept  = s_valid && s_ready;

   assign busy_o      = (state == S_SHIFT);
   assign done_o      = (state == S_DONE);
   assign det_data_o  = (state == S_SHIFT) && sh[WORD_W-1];
   assign det_rst_n_o = det_rst_n;
   assign match_cnt_o = match_cnt;
   assign match_any_o = (match_cnt != '0);
   assign underrun_o  = underrun;

   // Frame FSM, shift register, match counter and detector reset control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sh        <= '0;
         bitcnt    <= '0;
         last_q    <= 1'b0;
         match_cnt <= '0;
         underrun  <= 1'b0;
         det_rst_n <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sh        <= s_data;
                  bitcnt    <= BC_MAX;
                  last_q    <= s_last;
                  match_cnt <= '0;
                  underrun  <= 1'b0;
                  det_rst_n <= 1'b1;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Count detects for the bit currently on the wire, saturating.
               if (det_detect_i && (match_cnt != {CNT_W{1'b1}}))
                  match_cnt <= match_cnt + CNT_W'(1);
               if (bitcnt != '0) begin
                  sh     <= {sh[WORD_W-2:0], 1'b0};
                  bitcnt <= bitcnt - BC_W'(1);
               end else if (!last_q && s_valid) begin
                  // Seamless reload; the detector keeps its state across words.
                  sh     <= s_data;
                  bitcnt <= BC_MAX;
                  last_q <= s_last;
               end else begin
                  if (!last_q)
                     underrun <= 1'b1;
                  det_rst_n <= 1'b0;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               det_rst_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Scoreboard bench for seq_det_frame_ctrl: a behavioural 1011 Mealy detector
// sits on each DUT's serial output; stimulus pushes hand-computed frame
// results into a queue and a negedge monitor checks them on done_o.
module tb_seq_det_frame_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // DUT 1: default parameters
   logic       s_valid = 1'b0, s_last = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_ready, det_rst_n, det_data, det_detect, busy, done, any, und;
   logic [7:0] cnt;

   // DUT 2: 2-bit counter for saturation
   logic       s_valid2 = 1'b0, s_last2 = 1'b0;
   logic [7:0] s_data2 = 8'h00;
   logic       s_ready2, det_rst_n2, det_data2, det_detect2, busy2, done2, any2, und2;
   logic [1:0] cnt2;

   seq_det_frame_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .det_rst_n_o(det_rst_n),
      .det_data_o(det_data), .det_detect_i(det_detect), .busy_o(busy),
      .done_o(done), .match_cnt_o(cnt), .match_any_o(any), .underrun_o(und));

   seq_det_frame_ctrl #(.WORD_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2),
      .s_data(s_data2), .s_last(s_last2), .det_rst_n_o(det_rst_n2),
      .det_data_o(det_data2), .det_detect_i(det_detect2), .busy_o(busy2),
      .done_o(done2), .match_cnt_o(cnt2), .match_any_o(any2), .underrun_o(und2));

   // 1011 detector model: 0 none, 1 "1", 2 "10", 3 "101"
   function automatic logic [1:0] det_next(input logic [1:0] st, input logic b);
      case (st)
         2'd0:    return b ? 2'd1 : 2'd0;
         2'd1:    return b ? 2'd1 : 2'd2;
         2'd2:    return b ? 2'd3 : 2'd0;
         default: return b ? 2'd1 : 2'd2;
      endcase
   endfunction

   logic [1:0] dst = 2'd0, dst2 = 2'd0;
   always @(posedge clk or negedge det_rst_n)
      if (!det_rst_n) dst <= 2'd0; else dst <= det_next(dst, det_data);
   always @(posedge clk or negedge det_rst_n2)
      if (!det_rst_n2) dst2 <= 2'd0; else dst2 <= det_next(dst2, det_data2);
   assign det_detect  = (dst == 2'd3) && det_data;
   assign det_detect2 = (dst2 == 2'd3) && det_data2;

   typedef struct {
      string       name;
      int          cnt;
      bit          und;
      int          due;
      logic [31:0] bits;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor DUT 1: per-cycle invariants, serial bit capture, frame results on done.
   logic [31:0] bits1 = 32'h0;
   always @(negedge clk) begin
      if (!rst_n) bits1 = 32'h0;
      else begin
         chk("d1_det_rst_eq_busy", det_rst_n, busy);
         if (!busy) chk("d1_det_data_idle", det_data, 1'b0);
         if (busy) bits1 = {bits1[30:0], det_data};
         if (done) begin
            if (q1.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL d1_unexpected_done: got done_o=1 expected 0 at cycle %0d", cyc);
            end else begin
               e1 = q1.pop_front();
               chk({e1.name, "_cnt"},   cnt, e1.cnt);
               chk({e1.name, "_any"},   any, (e1.cnt != 0));
               chk({e1.name, "_und"},   und, e1.und);
               chk({e1.name, "_cycle"}, cyc, e1.due);
               chk({e1.name, "_bits"},  bits1, e1.bits);
               chk({e1.name, "_ready"}, s_ready, 1'b0);
            end
            bits1 = 32'h0;
         end
      end
   end

   // Monitor DUT 2: same checks for the narrow-counter instance.
   logic [31:0] bits2 = 32'h0;
   always @(negedge clk) begin
      if (!rst_n) bits2 = 32'h0;
      else begin
         chk("d2_det_rst_eq_busy", det_rst_n2, busy2);
         if (busy2) bits2 = {bits2[30:0], det_data2};
         if (done2) begin
            if (q2.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL d2_unexpected_done: got done_o=1 expected 0 at cycle %0d", cyc);
            end else begin
               e2 = q2.pop_front();
               chk({e2.name, "_cnt"},   cnt2, e2.cnt);
               chk({e2.name, "_any"},   any2, (e2.cnt != 0));
               chk({e2.name, "_und"},   und2, e2.und);
               chk({e2.name, "_cycle"}, cyc, e2.due);
               chk({e2.name, "_bits"},  bits2, e2.bits);
            end
            bits2 = 32'h0;
         end
      end
   end

   // Present a word at a negedge, wait for ready, return at the negedge after
   // the accept edge with the accept edge number. Leaves valid asserted.
   task automatic send(input int which, input logic [7:0] d, input logic l, output int acc);
      int n;
      n = 0;
      if (which == 1) begin s_valid = 1'b1; s_data = d; s_last = l; end
      else            begin s_valid2 = 1'b1; s_data2 = d; s_last2 = l; end
      while (n < 100 && !((which == 1) ? s_ready : s_ready2)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: got s_ready=0 expected 1 within 100 cycles");
         acc = -1;
      end else begin
         @(negedge clk);
         acc = cyc;
      end
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 200 && (q1.size() != 0 || q2.size() != 0); n++) @(negedge clk);
      if (q1.size() != 0 || q2.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q1.size() + q2.size());
         q1.delete();
         q2.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"},   s_ready,   1'b1);
      chk({tag, "_det_rst"}, det_rst_n, 1'b0);
      chk({tag, "_det_dat"}, det_data,  1'b0);
      chk({tag, "_busy"},    busy,      1'b0);
      chk({tag, "_done"},    done,      1'b0);
      chk({tag, "_cnt"},     cnt,       8'd0);
      chk({tag, "_any"},     any,       1'b0);
      chk({tag, "_und"},     und,       1'b0);
   endtask

   int a, b, c, d;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      chk("reset_d2_cnt", cnt2, 2'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single word 0xB0: detect on bit 3
      send(1, 8'hB0, 1'b1, a);
      s_valid = 1'b0;
      q1.push_back('{"single_b0", 1, 1'b0, a + 8, 32'h0000_00B0});
      wait_drain();
      chk("single_hold_cnt", cnt, 8'd1);
      chk("single_idle_ready", s_ready, 1'b1);

      // Overlapping matches in 0xBB: bits 3 and 7
      send(1, 8'hBB, 1'b1, a);
      s_valid = 1'b0;
      q1.push_back('{"overlap_bb", 2, 1'b0, a + 8, 32'h0000_00BB});
      wait_drain();

      // Pattern spanning the word boundary, no bubble between words
      send(1, 8'h0A, 1'b0, a);
      send(1, 8'hC0, 1'b1, b);
      s_valid = 1'b0;
      chk("cross_no_bubble", b, a + 8);
      q1.push_back('{"cross_0ac0", 1, 1'b0, a + 16, 32'h0000_0AC0});
      wait_drain();

      // Underrun: valid dropped at the boundary of a non-last word
      send(1, 8'hFF, 1'b0, a);
      s_valid = 1'b0;
      q1.push_back('{"underrun_ff", 0, 1'b1, a + 8, 32'h0000_00FF});
      wait_drain();
      chk("underrun_hold", und, 1'b1);
      chk("underrun_idle_ready", s_ready, 1'b1);
      chk("underrun_det_rst", det_rst_n, 1'b0);

      // Saturation on the 2-bit counter: 8 detects clamp to 3
      send(2, 8'hBB, 1'b0, a);
      send(2, 8'hBB, 1'b0, b);
      send(2, 8'hBB, 1'b0, c);
      send(2, 8'hBB, 1'b1, d);
      s_valid2 = 1'b0;
      q2.push_back('{"sat_4xbb", 3, 1'b0, a + 32, 32'hBBBB_BBBB});
      wait_drain();
      repeat (3) @(negedge clk);
      chk("sat_hold_cnt", cnt2, 2'd3);

      // Async reset in word 1 of a 2-word frame
      send(1, 8'hBB, 1'b0, a);
      s_data = 8'h0B;
      s_last = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_reset_cnt", cnt, 8'd1);
      chk("pre_reset_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      s_valid = 1'b0;
      #1 chk_reset_vals("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1, 8'hB0, 1'b1, a);
      s_valid = 1'b0;
      q1.push_back('{"after_reset_b0", 1, 1'b0, a + 8, 32'h0000_00B0});
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_det_frame_ctrl.md
Name: seq_det_frame_ctrl

Overview:
- Frame sequencer for the external 1011 serial pattern detector.
- Accepts parallel words from an upstream valid/ready stream and serialises them MSB-first into the detector's data input, one bit per clk.
- Holds the detector in reset between frames and counts Mealy detect pulses over each frame.
- Reports the per-frame match count, underrun status and a done pulse to the host logic.

Parameters:
WORD_W, 8, bits per input word (>=2)
CNT_W, 8, width of saturating match counter (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_valid  input  1  upstream word valid
s_ready  output  1  upstream word accepted when s_valid&&s_ready at posedge
s_data  input  WORD_W  word, transmitted MSB first
s_last  input  1  word is final word of frame
det_rst_n_o  output  1  registered active-low reset to detector
det_data_o  output  1  serial bit to detector data_i
det_detect_i  input  1  detector detect_o (combinational, same cycle as bit)
busy_o  output  1  frame in progress (state SHIFT)
done_o  output  1  one-cycle pulse at frame end
match_cnt_o  output  CNT_W  matches in last/current frame, saturating
match_any_o  output  1  match_cnt_o != 0
underrun_o  output  1  last frame aborted by upstream underrun

Behaviour:
- Reset (rst_n low, async): state IDLE, det_rst_n_o=0, shift reg=0, bit counter=0, last flag=0, match_cnt_o=0, underrun_o=0, done_o=0. Taking reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - s_ready=1.
  - On accept: load shift reg=s_data, bitcnt=WORD_W-1, last flag=s_last, clear match_cnt_o and underrun_o, det_rst_n_o<=1, go SHIFT.
- SHIFT:
  - det_data_o=shift reg MSB; busy_o=1.
  - Each cycle: if det_detect_i, match_cnt_o<=match_cnt_o+1, saturating at all-ones.
  - bitcnt!=0: shift left by 1, bitcnt-1, s_ready=0.
  - bitcnt==0, last flag=0: s_ready=1.
    - On accept: reload shift reg and last flag, bitcnt=WORD_W-1, stay SHIFT. The detector is not reset, so patterns span word boundaries.
    - No s_valid: underrun_o<=1, go DONE.
  - bitcnt==0, last flag=1: s_ready=0, go DONE.
  - det_rst_n_o<=0 on the transition to DONE.
- DONE:
  - done_o=1 for exactly this one cycle; s_ready=0; det_rst_n_o=0.
  - Next state IDLE.
- det_data_o=0 outside SHIFT.
- Results (match_cnt_o, match_any_o, underrun_o) hold from DONE until the first word of the next frame is accepted.
- s_ready is combinational from state/bitcnt/last flag only, never from s_valid.
- det_rst_n_o is registered: high exactly during SHIFT cycles, so the detector starts every frame in its initial state.
- Latency: frame of N words accepted without gaps → N*WORD_W SHIFT cycles; done_o in cycle N*WORD_W+1 after the first-word accept edge. Back-to-back frame accept is possible on the cycle after DONE.
- Throughput: 1 bit/clk, no bubbles between words when upstream is valid at the boundary.
- s_data/s_last are ignored when not accepted. s_valid is allowed to drop at any time except at a word boundary of a non-last word (underrun).

Test Plan:
- Single word s_data=0xB0, s_last=1 (WORD_W=8) → det_data_o sequence 1,0,1,1,0,0,0,0; one detect at bit 3; done_o pulse 9 cycles after accept; match_cnt_o=1, match_any_o=1, underrun_o=0.
- Overlap: 0xBB, s_last=1 → detects at bits 3 and 7; match_cnt_o=2.
- Cross-word: 0x0A (s_last=0) then 0xC0 (s_last=1), s_valid held high → second word accepted at bitcnt==0 with no bubble; pattern completes at first bit index 1 of word 2; match_cnt_o=1; done 17 cycles after first accept.
- Underrun: 0xFF (s_last=0), s_valid low at boundary → underrun_o=1, done_o pulse, match_cnt_o=0, det_rst_n_o=0 in DONE, back to IDLE with s_ready=1.
- Saturation with CNT_W=2: four words 0xBB, last on fourth → 8 detects, match_cnt_o=3 (held, no wrap).
- Async reset mid-frame: assert rst_n during word 1 of a 2-word frame → all outputs at reset values immediately, no done_o. New frame 0xB0 after release → match_cnt_o=1.
